qea_host_sequencer: RTL

//  Hardware host for the QEA accelerator: drives QEA's ctx/state RAM load ports, then

---
 rtl/qea_host_sequencer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/qea_host_sequencer.sv
// Hardware host for the QEA accelerator: loads ctx words, seeds the state RAM with |0>,
// starts QEA, times the run, then streams every final state RAM word out.
module qea_host_sequencer #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int RD_LATENCY              = 1,
    parameter int CYCLE_CNT_WIDTH         = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_run,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
    input  logic                                 s_ctx_valid,
    output logic                                 s_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   s_ctx_data,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic [PE_NUM-1:0]                    o_state_ena,
    output logic [PE_NUM-1:0]                    o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    output logic                                 o_start,
    input  logic                                 i_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
    output logic                                 m_res_valid,
    input  logic                                 m_res_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   m_res_data,
    output logic                                 m_res_last,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic [CYCLE_CNT_WIDTH-1:0]           o_cycles
);
    // state        | meaning
    // S_IDLE       | waiting for i_run
    // S_LOAD_CTX   | accepting ctx stream words into ctx RAM
    // S_INIT_STATE | writing |0> into state RAM, one word per cycle
    // S_START      | one-cycle start pulse, cycle counter restarts
    // S_WAIT       | counting until QEA reports complete
    // S_RD_ISSUE   | state RAM read request for word j
    // S_RD_WAIT    | RAM read latency
    // S_RD_OUT     | result word j offered downstream
    // S_DONE       | one-cycle done pulse
    localparam int WW   = PE_NUM * STATE_DATA_WIDTH;
    localparam int CAW  = GATE_CONTEXT_ADDR_WIDTH;
    localparam int SAW  = STATE_ADDR_WIDTH;
    localparam int QW   = MAX_QBIT_WIDTH;
    localparam int CCW  = CYCLE_CNT_WIDTH;
    localparam int LATW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [STATE_DATA_WIDTH-1:0] ONE_RE = STATE_DATA_WIDTH'(1) << (NUM_FRAC_BIT + DATA_WIDTH);
    localparam logic [WW-1:0] INIT_WORD = WW'(ONE_RE) << (WW - STATE_DATA_WIDTH);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_CTX, S_INIT_STATE, S_START, S_WAIT,
        S_RD_ISSUE, S_RD_WAIT, S_RD_OUT, S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [QW-1:0]   qbit_q, qbit_d;
    logic [CAW-1:0]  ins_q, ins_d;
    logic [CAW-1:0]  ctx_cnt_q, ctx_cnt_d;
    logic [SAW-1:0]  word_cnt_q, word_cnt_d;
    logic [LATW-1:0] lat_cnt_q, lat_cnt_d;
    logic [1:0]      wait_cnt_q, wait_cnt_d;
    logic [CCW-1:0]  cycles_q, cycles_d;
    logic            ctx_en_q, ctx_en_d;
    logic [CAW-1:0]  ctx_addr_q, ctx_addr_d;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_q, ctx_data_d;
    logic [WW-1:0]   res_q, res_d;
    logic [QW-1:0]   nw_exp;
    logic [SAW-1:0]  last_idx;

    // Index of the last state word; saturates instead of wrapping for oversized jobs.
    always_comb begin
        nw_exp = qbit_q - QW'(PE_NUM_WIDTH);
        if (qbit_q <= QW'(PE_NUM_WIDTH))
            last_idx = '0;
        else if (nw_exp >= QW'(SAW))
            last_idx = '1;
        else
            last_idx = (SAW'(1) << nw_exp) - SAW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            qbit_q     <= '0;
            ins_q      <= '0;
            ctx_cnt_q  <= '0;
            word_cnt_q <= '0;
            lat_cnt_q  <= '0;
            wait_cnt_q <= '0;
            cycles_q   <= '0;
            ctx_en_q   <= 1'b0;
            ctx_addr_q <= '0;
            ctx_data_q <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            qbit_q     <= qbit_d;
            ins_q      <= ins_d;
            ctx_cnt_q  <= ctx_cnt_d;
            word_cnt_q <= word_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            cycles_q   <= cycles_d;
            ctx_en_q   <= ctx_en_d;
            ctx_addr_q <= ctx_addr_d;
            ctx_data_q <= ctx_data_d;
            res_q      <= res_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        qbit_d        = qbit_q;
        ins_d         = ins_q;
        ctx_cnt_d     = ctx_cnt_q;
        word_cnt_d    = word_cnt_q;
        lat_cnt_d     = lat_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        cycles_d      = cycles_q;
        ctx_en_d      = 1'b0;
        ctx_addr_d    = ctx_addr_q;
        ctx_data_d    = ctx_data_q;
        res_d         = res_q;
        s_ctx_ready   = 1'b0;
        o_state_ena   = '0;
        o_state_wea   = '0;
        o_state_addra = '0;
        o_state_dina  = '0;
        o_start       = 1'b0;
        m_res_valid   = 1'b0;
        m_res_last    = 1'b0;
        o_busy        = (state_q != S_IDLE) && (state_q != S_DONE);
        o_done        = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    qbit_d     = i_qbit_num;
                    ins_d      = i_ins_num;
                    ctx_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = (i_ins_num == '0) ? S_INIT_STATE : S_LOAD_CTX;
                end
            end
            S_LOAD_CTX: begin
                s_ctx_ready = 1'b1;
                if (s_ctx_valid) begin
                    ctx_en_d   = 1'b1;
                    ctx_addr_d = ctx_cnt_q;
                    ctx_data_d = s_ctx_data;
                    ctx_cnt_d  = ctx_cnt_q + CAW'(1);
                    if (ctx_cnt_q == ins_q - CAW'(1))
                        state_d = S_INIT_STATE;
                end
            end
            S_INIT_STATE: begin
                o_state_ena   = '1;
                o_state_wea   = '1;
                o_state_addra = word_cnt_q;
                o_state_dina  = (word_cnt_q == '0) ? INIT_WORD : '0;
                if (word_cnt_q == last_idx) begin
                    word_cnt_d = '0;
                    state_d    = S_START;
                end else begin
                    word_cnt_d = word_cnt_q + SAW'(1);
                end
            end
            S_START: begin
                o_start    = 1'b1;
                cycles_d   = CCW'(1);
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + CCW'(1);
                // QEA's complete level from the previous job is still visible for two cycles.
                if (wait_cnt_q != 2'd2)
                    wait_cnt_d = wait_cnt_q + 2'd1;
                else if (i_complete)
                    state_d = S_RD_ISSUE;
            end
            S_RD_ISSUE: begin
                o_state_ena   = '1;
                o_state_addra = word_cnt_q;
                lat_cnt_d     = '0;
                state_d       = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_cnt_q == LATW'(RD_LATENCY - 1)) begin
                    res_d   = i_state_dout;
                    state_d = S_RD_OUT;
                end else begin
                    lat_cnt_d = lat_cnt_q + LATW'(1);
                end
            end
            S_RD_OUT: begin
                m_res_valid = 1'b1;
                m_res_last  = (word_cnt_q == last_idx);
                if (m_res_ready) begin
                    if (word_cnt_q == last_idx) begin
                        state_d = S_DONE;
                    end else begin
                        word_cnt_d = word_cnt_q + SAW'(1);
                        state_d    = S_RD_ISSUE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign o_ctx_en   = ctx_en_q;
    assign o_ctx_wea  = ctx_en_q;
    assign o_ctx_addr = ctx_addr_q;
    assign o_ctx_data = ctx_data_q;
    assign m_res_data = res_q;
    assign o_cycles   = cycles_q;

endmodule
